level_counter_ctrl: RTL and testbench
=====================================

// Module: level_counter_ctrl
// PURPOSE
//   Upstream source for the 7-segment decoder: turns two raw push-buttons
//   (up/down) into a saturating 0..MAX_VAL level on val[2:0].
//   Synchronizes, debounces and edge-detects each button, then steps the level.
//   val drives the decoder's val input directly.
// PARAMETERS
//   DEBOUNCE_CYCLES  250000      consecutive stable samples needed to accept a new level (10 ms @25 MHz)
//   MAX_VAL          4           upper saturation limit of val (must be <= 7)
//   REPEAT_CYCLES    12500000    hold time per auto-repeat step (used only with the macro)
// PORTS
//   clk        in   1  single system clock, rising edge
//   rst        in   1  synchronous, active-high reset
//   btn_up_i   in   1  raw, asynchronous, active-high "up" button
//   btn_dn_i   in   1  raw, asynchronous, active-high "down" button
//   val        out  3  current level 0..MAX_VAL, registered
//   at_max     out  1  high when val == MAX_VAL, registered
//   at_min     out  1  high when val == 0, registered
//   step_o     out  1  one-cycle pulse in the cycle val changes
// BEHAVIOUR
//   - Reset (rst sampled high at clk edge): val=0, at_min=1, at_max=0, step_o=0.
//     Sync flops, debounce counters and debounced levels clear to 0.
//     A button held through reset release is treated as a new press.
//   - Per button: 2-FF synchronizer, then debouncer.
//     The debounce counter restarts whenever the sync output equals the
//     debounced level. When it differs for DEBOUNCE_CYCLES consecutive cycles,
//     the debounced level toggles.
//   - Press pulse: rising edge of the debounced level, 1 cycle.
//     Release generates nothing.
//   - Latency: raw input stable high from edge k -> val updated at edge
//     k+DEBOUNCE_CYCLES+3 (2 sync + DEBOUNCE_CYCLES + 1 register).
//   - Glitches shorter than DEBOUNCE_CYCLES never change val.
//   - Update rules, one per cycle:
//       up pulse only, val<MAX_VAL -> val+1, step_o=1
//       dn pulse only, val>0       -> val-1, step_o=1
//       up at MAX_VAL or dn at 0   -> no change, step_o=0 (saturate, no wrap)
//       up and dn same cycle       -> no change, step_o=0
//   - at_max/at_min update in the same cycle as val (no extra latency).
//   - val never exceeds MAX_VAL, so the decoder's dash code is never produced.
// CONFIGURATION
//   LEVEL_CTR_AUTO_REPEAT_EN defined:
//     - While a debounced level stays high, an extra press pulse is generated
//       after REPEAT_CYCLES, then every REPEAT_CYCLES.
//     - The repeat timer clears on release and on reset.
//     - Saturation and simultaneous-press rules are unchanged.
//   Not defined:
//     - Exactly one press pulse per debounced press.
//     - REPEAT_CYCLES is ignored and no repeat logic is synthesized.
// STRUCTURE
//   Shared package/header holds:
//     - LEVEL_W=3
//     - LEVEL_MAX_DEFAULT=4
//     - debounce/repeat default constants, shared with the decoder's 0..4 contract
//   Sub-module btn_debounce (sync + debounce + rising-edge pulse, parameter
//   DEBOUNCE_CYCLES), instantiated twice. The top holds the level register and
//   the optional repeat timers.
// TESTING  (sim: DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, MAX_VAL=4)
//   1. Reset, then idle 20 cycles -> val=0, at_min=1, at_max=0, step_o=0.
//   2. btn_up high from edge k for 20 cycles -> val=1 at edge k+7,
//      step_o high that cycle only, no further change.
//   3. Five up presses (each 10 high / 10 low) -> val 1,2,3,4,4;
//      at_max=1 after the 4th; 5th gives step_o=0.
//   4. 3-cycle pulse on btn_dn at val=2 -> val stays 2.
//      Then up and dn asserted on the same edge for 20 cycles -> val stays 2.
//   5. rst asserted for 1 cycle mid-debounce (cycle 2 of 4) while btn_up held ->
//      val=0 next edge; val=1 exactly 7 edges after rst deasserts.
//   6. [LEVEL_CTR_AUTO_REPEAT_EN] btn_up held 40 cycles from val=0 ->
//      steps at +7, +15, +23, +31; val saturates at 4.
//      Without the macro -> val=1 only.

Source files
------------

// File: rtl/level_counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : level_counter_ctrl_pkg
// Brief    : Shared widths, defaults and step decode for the level counter.
// Revision : 1.0 - initial release
// ============================================================================
package level_counter_ctrl_pkg;

  localparam int LEVEL_W                 = 3;
  localparam int LEVEL_MAX_DEFAULT       = 4;        // decoder accepts 0..4
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;   // 10 ms @ 25 MHz
  localparam int REPEAT_CYCLES_DEFAULT   = 12500000; // 0.5 s @ 25 MHz

  localparam int BTN_UP = 0;
  localparam int BTN_DN = 1;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2
  } step_e;

  // Simultaneous requests cancel; saturated requests are dropped.
  function automatic step_e decode_step(input logic up, input logic dn,
                                        input logic at_top, input logic at_bottom);
    step_e s;
    s = STEP_NONE;
    if (up && !dn && !at_top)
      s = STEP_INC;
    else if (dn && !up && !at_bottom)
      s = STEP_DEC;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/level_counter_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : 2-FF synchronizer, counting debouncer and registered press pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
  import level_counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level,
  output logic press
);

  localparam int             CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      // Any sample agreeing with the accepted level restarts the qualification window.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/level_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : level_counter_ctrl
// Brief    : Two debounced push-buttons step a saturating 0..MAX_VAL level.
//            Optional auto-repeat on held buttons: LEVEL_CTR_AUTO_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module level_counter_ctrl
  import level_counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int MAX_VAL         = LEVEL_MAX_DEFAULT,      // must be <= 7
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up_i,
  input  logic               btn_dn_i,
  output logic [LEVEL_W-1:0] val,
  output logic               at_max,
  output logic               at_min,
  output logic               step_o
);

  localparam logic [LEVEL_W-1:0] LEVEL_TOP = LEVEL_W'(MAX_VAL);

  logic [1:0]         w_level;
  logic [1:0]         w_press;
  logic [1:0]         w_req;
  step_e              w_step;
  logic [LEVEL_W-1:0] r_val;
  logic               r_at_max;
  logic               r_at_min;
  logic               r_step;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_up_i),
    .level (w_level[BTN_UP]),
    .press (w_press[BTN_UP])
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_dn_i),
    .level (w_level[BTN_DN]),
    .press (w_press[BTN_DN])
  );

`ifdef LEVEL_CTR_AUTO_REPEAT_EN
  localparam int               RPT_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  for (genvar gi = 0; gi < 2; gi++) begin : g_rpt
    logic [RPT_W-1:0] r_rpt_cnt;
    logic             r_rpt_pulse;

    // Timer starts the cycle after the level rises, so the first repeat
    // lands REPEAT_CYCLES after the initial press step.
    always_ff @(posedge clk) begin
      if (rst || !w_level[gi]) begin
        r_rpt_cnt   <= '0;
        r_rpt_pulse <= 1'b0;
      end else if (r_rpt_cnt == RPT_LAST) begin
        r_rpt_cnt   <= '0;
        r_rpt_pulse <= 1'b1;
      end else begin
        r_rpt_cnt   <= r_rpt_cnt + 1'b1;
        r_rpt_pulse <= 1'b0;
      end
    end

    assign w_req[gi] = w_press[gi] | r_rpt_pulse;
  end
`else
  logic w_unused_rpt;
  assign w_req        = w_press;
  assign w_unused_rpt = ^{w_level, (REPEAT_CYCLES > 0)};
`endif

  always_comb begin
    w_step = STEP_NONE;
    w_step = decode_step(w_req[BTN_UP], w_req[BTN_DN], r_val == LEVEL_TOP, r_val == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val    <= '0;
      r_at_max <= 1'b0;
      r_at_min <= 1'b1;
      r_step   <= 1'b0;
    end else begin
      r_step <= 1'b0;
      case (w_step)
        STEP_INC: begin
          r_val    <= r_val + 1'b1;
          r_at_max <= (r_val + 1'b1) == LEVEL_TOP;
          r_at_min <= 1'b0;
          r_step   <= 1'b1;
        end
        STEP_DEC: begin
          r_val    <= r_val - 1'b1;
          r_at_max <= 1'b0;
          r_at_min <= r_val == LEVEL_W'(1);
          r_step   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign val    = r_val;
  assign at_max = r_at_max;
  assign at_min = r_at_min;
  assign step_o = r_step;

endmodule
`default_nettype wire

// File: tb/tb_level_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_level_counter_ctrl
// Brief    : Directed self-checking bench for level_counter_ctrl (DB=4, RPT=8, MAX=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_level_counter_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_up_i;
  logic       btn_dn_i;
  logic [2:0] val;
  logic       at_max;
  logic       at_min;
  logic       step_o;

  int n_cmp;
  int n_err;

  level_counter_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .MAX_VAL         (4),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up_i (btn_up_i),
    .btn_dn_i (btn_dn_i),
    .val      (val),
    .at_max   (at_max),
    .at_min   (at_min),
    .step_o   (step_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // Stimulus only: hold buttons for hi cycles, then release for lo cycles.
  task automatic press(input logic up, input logic dn, input int hi, input int lo);
    btn_up_i = up;
    btn_dn_i = dn;
    tick(hi);
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
    tick(lo);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_up_i = 1'b0; btn_dn_i = 1'b0;
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      n_cmp++;
      if (step_o !== 1'b0) begin
        n_err++; $display("FAIL reset_idle_step cyc=%0d got=%b exp=0", i, step_o);
      end
    end
    n_cmp++; if (val !== 3'd0)   begin n_err++; $display("FAIL reset_val got=%0d exp=0", val); end
    n_cmp++; if (at_min !== 1'b1) begin n_err++; $display("FAIL reset_at_min got=%b exp=1", at_min); end
    n_cmp++; if (at_max !== 1'b0) begin n_err++; $display("FAIL reset_at_max got=%b exp=0", at_max); end
  endtask

  task automatic test_single_up();
    btn_up_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      n_cmp++;
      if (val !== ((i >= 7) ? 3'd1 : 3'd0)) begin
        n_err++; $display("FAIL single_up_val edge=+%0d got=%0d exp=%0d", i, val, (i >= 7) ? 1 : 0);
      end
      n_cmp++;
      if (step_o !== (i == 7)) begin
        n_err++; $display("FAIL single_up_step edge=+%0d got=%b exp=%b", i, step_o, (i == 7));
      end
    end
    btn_up_i = 1'b0;
    tick(20);
    n_cmp++;
    if (val !== 3'd1 || at_min !== 1'b0) begin
      n_err++; $display("FAIL single_up_release got val=%0d at_min=%b exp val=1 at_min=0", val, at_min);
    end
  endtask

  task automatic test_five_up();
    logic [2:0] exp_val;
    logic       exp_step;
    pulse_rst();
    exp_val = 3'd0;
    for (int p = 0; p < 5; p++) begin
      exp_step = (exp_val < 3'd4);
      btn_up_i = 1'b1;
      for (int i = 1; i <= 10; i++) begin
        tick(1);
        if (i == 6) begin
          n_cmp++;
          if (val !== exp_val) begin
            n_err++; $display("FAIL five_up_pre press=%0d got=%0d exp=%0d", p, val, exp_val);
          end
        end
        if (i == 7) begin
          if (exp_step) exp_val = exp_val + 3'd1;
          n_cmp++;
          if (val !== exp_val) begin
            n_err++; $display("FAIL five_up_val press=%0d got=%0d exp=%0d", p, val, exp_val);
          end
          n_cmp++;
          if (step_o !== exp_step) begin
            n_err++; $display("FAIL five_up_step press=%0d got=%b exp=%b", p, step_o, exp_step);
          end
          n_cmp++;
          if (at_max !== (exp_val == 3'd4)) begin
            n_err++; $display("FAIL five_up_at_max press=%0d got=%b exp=%b", p, at_max, (exp_val == 3'd4));
          end
        end
      end
      btn_up_i = 1'b0;
      tick(10);
    end
  endtask

  task automatic test_down();
    press(1'b0, 1'b1, 10, 10);
    n_cmp++;
    if (val !== 3'd3 || at_max !== 1'b0) begin
      n_err++; $display("FAIL down_first got val=%0d at_max=%b exp val=3 at_max=0", val, at_max);
    end
    press(1'b0, 1'b1, 10, 10);
    n_cmp++;
    if (val !== 3'd2) begin n_err++; $display("FAIL down_second got=%0d exp=2", val); end
  endtask

  task automatic test_glitch_and_both();
    btn_dn_i = 1'b1;
    tick(3);
    btn_dn_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      n_cmp++;
      if (step_o !== 1'b0) begin n_err++; $display("FAIL glitch_step cyc=%0d got=%b exp=0", i, step_o); end
    end
    n_cmp++;
    if (val !== 3'd2) begin n_err++; $display("FAIL glitch_val got=%0d exp=2", val); end

    btn_up_i = 1'b1;
    btn_dn_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      n_cmp++;
      if (step_o !== 1'b0 || val !== 3'd2) begin
        n_err++; $display("FAIL both_press cyc=%0d got val=%0d step=%b exp val=2 step=0", i, val, step_o);
      end
    end
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
    tick(20);
    n_cmp++;
    if (val !== 3'd2) begin n_err++; $display("FAIL both_release got=%0d exp=2", val); end
  endtask

  task automatic test_reset_mid();
    btn_up_i = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_cmp++;
    if (val !== 3'd0 || at_min !== 1'b1 || at_max !== 1'b0 || step_o !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_clear got val=%0d min=%b max=%b step=%b exp 0/1/0/0",
                        val, at_min, at_max, step_o);
    end
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      n_cmp++;
      if (val !== ((i == 7) ? 3'd1 : 3'd0)) begin
        n_err++; $display("FAIL reset_mid_val edge=+%0d got=%0d exp=%0d", i, val, (i == 7) ? 1 : 0);
      end
    end
    n_cmp++;
    if (step_o !== 1'b1) begin n_err++; $display("FAIL reset_mid_step got=%b exp=1", step_o); end
    btn_up_i = 1'b0;
    tick(20);
  endtask

  task automatic test_dn_at_min();
    press(1'b0, 1'b1, 10, 10);
    n_cmp++;
    if (val !== 3'd0 || at_min !== 1'b1) begin
      n_err++; $display("FAIL dn_to_min got val=%0d at_min=%b exp val=0 at_min=1", val, at_min);
    end
    btn_dn_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      n_cmp++;
      if (val !== 3'd0 || step_o !== 1'b0) begin
        n_err++; $display("FAIL dn_saturate edge=+%0d got val=%0d step=%b exp val=0 step=0", i, val, step_o);
      end
    end
    btn_dn_i = 1'b0;
    tick(10);
  endtask

  task automatic test_auto_repeat();
    logic [2:0] exp_val;
    logic       exp_step;
    pulse_rst();
    exp_val = 3'd0;
    btn_up_i = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
`ifdef LEVEL_CTR_AUTO_REPEAT_EN
      exp_step = (i == 7) || (i == 15) || (i == 23) || (i == 31);
`else
      exp_step = (i == 7);
`endif
      if (exp_step) exp_val = exp_val + 3'd1;
      n_cmp++;
      if (val !== exp_val || step_o !== exp_step) begin
        n_err++; $display("FAIL auto_repeat edge=+%0d got val=%0d step=%b exp val=%0d step=%b",
                          i, val, step_o, exp_val, exp_step);
      end
    end
    btn_up_i = 1'b0;
    tick(20);
    n_cmp++;
    if (val !== exp_val) begin n_err++; $display("FAIL auto_repeat_release got=%0d exp=%0d", val, exp_val); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
    test_reset();
    test_single_up();
    test_five_up();
    test_down();
    test_glitch_and_both();
    test_reset_mid();
    test_dn_at_min();
    test_auto_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
